// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: pipelined N-to-1 multiplexer for W-bit channels, built as a
// tree of registered 4:1 nodes, with a valid bit and channel tag carried
// alongside the data and an auto-scan mode for time-division readout.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    N*W packed channels; channel c at [c*W +: W]
//   in_valid   current in_data/sel sample is valid
//   sel        direct channel select (mode = 0)
//   mode       0 = direct select, 1 = auto-scan through 0..N-1
//   out_data   selected channel, L cycles after the sample
//   out_valid  out_data/out_ch valid
//   out_ch     channel index delivered on out_data

// One registered 4:1 node of the tree.
module mux4_node #(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0][W-1:0] i_d,
  input  logic [1:0]        i_s,
  output logic [W-1:0]      o_q
);
  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= '0;
    else        r_q <= i_d[i_s];
  end

  assign o_q = r_q;
endmodule

module mux_tree_pipe #(
  parameter int W  = 8,
  parameter int N  = 16,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic           in_valid,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  output logic [SW-1:0]  out_ch
);
  // Tree depth L = ceil(log4 N) for N in 2..256.
  localparam int L  = (N <= 4) ? 1 : (N <= 16) ? 2 : (N <= 64) ? 3 : 4;
  localparam int SL = 2 * L;          // select width padded to 2 bits per stage
  localparam int NP = 4 ** L;         // padded leaf count
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  // Scan counter: wraps at N-1, holds on bubbles, parked at 0 outside scan
  // mode so every entry into scan mode starts at channel 0.
  logic [SW-1:0] r_scan_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_scan_ch <= '0;
    else if (!mode)    r_scan_ch <= '0;
    else if (in_valid) r_scan_ch <= (r_scan_ch == LAST) ? '0 : r_scan_ch + 1'b1;
  end

  logic [SW-1:0] w_eff;
  logic [SL-1:0] w_eff_pad;
  assign w_eff     = mode ? r_scan_ch : sel;
  assign w_eff_pad = SL'(w_eff);

  // Leaves padded to 4^L with zeros. Since 2^SW <= 4^L, any select >= N
  // lands on a zero leaf, which yields out_data = 0 for out-of-range
  // channels without extra logic.
  logic [NP-1:0][W-1:0] w_pad;

  always_comb begin
    w_pad = '0;
    for (int c = 0; c < N; c++) w_pad[c] = in_data[c*W +: W];
  end

  // Select/tag and valid travel with the data; stage k reads its select
  // bits from the copy registered with stage k-1's data.
  logic [L-1:0][SL-1:0] r_sel;
  logic [L:1]           r_vld_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel      <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_sel[0]      <= w_eff_pad;
      r_vld_pipe[1] <= in_valid;
      for (int k = 1; k < L; k++) begin
        r_sel[k]        <= r_sel[k-1];
        r_vld_pipe[k+1] <= r_vld_pipe[k];
      end
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_stg
    localparam int NN = 4 ** (L - 1 - k);
    logic [4*NN-1:0][W-1:0] w_d;
    logic [NN-1:0][W-1:0]   w_q;
    logic [1:0]             w_s;

    if (k == 0) begin : g_leaf
      assign w_d = w_pad;
      assign w_s = w_eff_pad[1:0];
    end else begin : g_inner
      assign w_d = g_stg[k-1].w_q;
      assign w_s = r_sel[k-1][2*k+1:2*k];
    end

    for (genvar n = 0; n < NN; n++) begin : g_node
      mux4_node #(.W(W)) u_node (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (w_d[4*n+3 -: 4]),
        .i_s   (w_s),
        .o_q   (w_q[n])
      );
    end
  end

  assign out_data  = g_stg[L-1].w_q[0];
  assign out_valid = r_vld_pipe[L];
  assign out_ch    = r_sel[L-1][SW-1:0];

  // Padding bits above SW in the final tag copy are never delivered.
  logic w_unused_tag;
  assign w_unused_tag = ^r_sel[L-1];
endmodule

// File: tb/tb_mux_tree_pipe.sv
module tb_mux_tree_pipe;
  localparam int ND = 4;
  localparam int NN    [ND] = '{16, 5, 10, 4};
  localparam int LL    [ND] = '{2, 2, 2, 1};
  localparam int SMASK [ND] = '{15, 7, 15, 3};
  localparam int WMASK [ND] = '{255, 15, 255, 255};

  typedef struct { logic v; logic [7:0] data; int ch; } exp_t;
  typedef struct { logic [7:0] sel; logic vld; logic [7:0] exp_data; logic [7:0] exp_ch; logic exp_vld; } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] chd   [ND][16];
  logic [7:0] sel_i [ND];
  logic       vld_i [ND];
  logic       mode_i[ND];
  logic [7:0] od_a  [ND];
  logic [7:0] oc_a  [ND];
  logic       ov    [ND];

  logic [127:0] id0; logic [19:0] id1; logic [79:0] id2; logic [31:0] id3;
  logic [7:0] od0; logic [3:0] od1; logic [7:0] od2; logic [7:0] od3;
  logic [3:0] oc0; logic [2:0] oc1; logic [3:0] oc2; logic [1:0] oc3;

  always_comb begin
    id0 = '0; id1 = '0; id2 = '0; id3 = '0;
    for (int c = 0; c < 16; c++) id0[c*8 +: 8] = chd[0][c];
    for (int c = 0; c < 5;  c++) id1[c*4 +: 4] = chd[1][c][3:0];
    for (int c = 0; c < 10; c++) id2[c*8 +: 8] = chd[2][c];
    for (int c = 0; c < 4;  c++) id3[c*8 +: 8] = chd[3][c];
  end

  assign od_a[0] = od0; assign od_a[1] = {4'h0, od1}; assign od_a[2] = od2; assign od_a[3] = od3;
  assign oc_a[0] = {4'h0, oc0}; assign oc_a[1] = {5'h0, oc1}; assign oc_a[2] = {4'h0, oc2}; assign oc_a[3] = {6'h0, oc3};

  mux_tree_pipe #(.W(8), .N(16)) u_n16 (.clk(clk), .rst_n(rst_n), .in_data(id0), .in_valid(vld_i[0]),
    .sel(sel_i[0][3:0]), .mode(mode_i[0]), .out_data(od0), .out_valid(ov[0]), .out_ch(oc0));
  mux_tree_pipe #(.W(4), .N(5)) u_n5 (.clk(clk), .rst_n(rst_n), .in_data(id1), .in_valid(vld_i[1]),
    .sel(sel_i[1][2:0]), .mode(mode_i[1]), .out_data(od1), .out_valid(ov[1]), .out_ch(oc1));
  mux_tree_pipe #(.W(8), .N(10)) u_n10 (.clk(clk), .rst_n(rst_n), .in_data(id2), .in_valid(vld_i[2]),
    .sel(sel_i[2][3:0]), .mode(mode_i[2]), .out_data(od2), .out_valid(ov[2]), .out_ch(oc2));
  mux_tree_pipe #(.W(8), .N(4)) u_n4 (.clk(clk), .rst_n(rst_n), .in_data(id3), .in_valid(vld_i[3]),
    .sel(sel_i[3][1:0]), .mode(mode_i[3]), .out_data(od3), .out_valid(ov[3]), .out_ch(oc3));

  int checks = 0;
  int failures = 0;
  int scan_m[ND];
  exp_t hist[ND][$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each sample's result is what the channel rules say,
  // delivered L cycles later (queue preloaded with L-1 empty slots).
  task automatic step();
    for (int d = 0; d < ND; d++) begin
      exp_t e;
      int ch;
      ch = mode_i[d] ? scan_m[d] : (int'(sel_i[d]) & SMASK[d]);
      e.v = vld_i[d];
      e.ch = ch;
      e.data = (ch < NN[d]) ? chd[d][ch] : 8'h00;
      hist[d].push_back(e);
      if (!mode_i[d])    scan_m[d] = 0;
      else if (vld_i[d]) scan_m[d] = (scan_m[d] + 1) % NN[d];
    end
    @(posedge clk); #1;
    for (int d = 0; d < ND; d++) begin
      exp_t e;
      e = hist[d].pop_front();
      chk($sformatf("model_d%0d_vld", d), ov[d], e.v);
      if (e.v) begin
        chk($sformatf("model_d%0d_data", d), od_a[d], e.data);
        chk($sformatf("model_d%0d_ch", d), oc_a[d], e.ch);
      end
    end
  endtask

  task automatic exp1(input int d, input string nm, input logic v, input int ch, input int data);
    chk({nm, "_vld"}, ov[d], v);
    if (v) begin
      chk({nm, "_ch"}, oc_a[d], ch);
      chk({nm, "_data"}, od_a[d], data);
    end
  endtask

  task automatic idle();
    for (int d = 0; d < ND; d++) begin
      vld_i[d] = 1'b0; mode_i[d] = 1'b0; sel_i[d] = 8'h0;
    end
  endtask

  task automatic do_reset(input string nm);
    exp_t z;
    z.v = 1'b0; z.data = 8'h0; z.ch = 0;
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("%s_d%0d_vld", nm, d), ov[d], 1'b0);
      chk($sformatf("%s_d%0d_data", nm, d), od_a[d], 8'h0);
      chk($sformatf("%s_d%0d_ch", nm, d), oc_a[d], 8'h0);
      hist[d].delete();
      for (int k = 1; k < LL[d]; k++) hist[d].push_back(z);
      scan_m[d] = 0;
    end
    @(posedge clk); #3 rst_n = 1'b1;
  endtask

  vec_t tv[26];

  initial begin
    idle();
    for (int d = 0; d < ND; d++)
      for (int c = 0; c < 16; c++) chd[d][c] = 8'h0;
    for (int c = 0; c < 16; c++) chd[0][c] = 8'h10 + 8'(c);
    for (int c = 0; c < 5;  c++) chd[1][c] = 8'(c + 3);
    for (int c = 0; c < 10; c++) chd[2][c] = 8'hA0 + 8'(c);
    for (int c = 0; c < 4;  c++) chd[3][c] = 8'h30 + 8'(c);

    // Direct select sweep then bubble alternation, N=16 (L=2).
    for (int i = 0; i < 26; i++) begin
      tv[i].sel = (i < 16) ? 8'(i) : 8'((i * 7) % 16);
      tv[i].vld = (i < 16) ? 1'b1 : ((i % 2) == 0);
      if (i == 0) begin
        tv[i].exp_vld = 1'b0; tv[i].exp_data = 8'h0; tv[i].exp_ch = 8'h0;
      end else begin
        tv[i].exp_vld  = tv[i-1].vld;
        tv[i].exp_data = 8'h10 + tv[i-1].sel;
        tv[i].exp_ch   = tv[i-1].sel;
      end
    end

    do_reset("reset");
    for (int i = 0; i < 26; i++) begin
      sel_i[0] = tv[i].sel; vld_i[0] = tv[i].vld;
      step();
      chk($sformatf("t1_vld_%0d", i), ov[0], tv[i].exp_vld);
      if (tv[i].exp_vld) begin
        chk($sformatf("t1_data_%0d", i), od_a[0], tv[i].exp_data);
        chk($sformatf("t1_ch_%0d", i), oc_a[0], tv[i].exp_ch);
      end
    end
    idle(); step();

    // Auto-scan wrap, N=5.
    begin
      int sc[12] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1};
      mode_i[1] = 1'b1; vld_i[1] = 1'b1;
      for (int j = 0; j <= 12; j++) begin
        if (j == 12) vld_i[1] = 1'b0;
        step();
        if (j >= 1) exp1(1, $sformatf("scan_wrap_%0d", j), 1'b1, sc[j-1], sc[j-1] + 3);
      end
    end

    // Scan hold on bubbles and re-entry at channel 0.
    mode_i[1] = 1'b0; vld_i[1] = 1'b0; step();
    mode_i[1] = 1'b1; vld_i[1] = 1'b1; step();
    vld_i[1] = 1'b1; step(); exp1(1, "hold_a", 1'b1, 0, 3);
    vld_i[1] = 1'b0; step(); exp1(1, "hold_b", 1'b1, 1, 4);
    vld_i[1] = 1'b0; step(); exp1(1, "hold_c", 1'b0, 0, 0);
    vld_i[1] = 1'b1; step(); exp1(1, "hold_d", 1'b0, 0, 0);
    mode_i[1] = 1'b0; sel_i[1] = 8'd4; step(); exp1(1, "hold_e", 1'b1, 2, 5);
    mode_i[1] = 1'b1; step(); exp1(1, "reentry_direct", 1'b1, 4, 7);
    vld_i[1] = 1'b0; step(); exp1(1, "reentry_scan0", 1'b1, 0, 3);
    idle(); step();

    // Out-of-range select, N=10, around the N boundary.
    vld_i[2] = 1'b1; sel_i[2] = 8'd12; step();
    sel_i[2] = 8'd9;  step(); exp1(2, "oor_12", 1'b1, 12, 0);
    sel_i[2] = 8'd10; step(); exp1(2, "last_9", 1'b1, 9, 8'hA9);
    vld_i[2] = 1'b0;  step(); exp1(2, "oor_10", 1'b1, 10, 0);

    // Single-stage tree, N=4 (L=1).
    vld_i[3] = 1'b1; sel_i[3] = 8'd2; step(); exp1(3, "l1_a", 1'b1, 2, 8'h32);
    vld_i[3] = 1'b0; sel_i[3] = 8'd3; step(); exp1(3, "l1_b", 1'b0, 0, 0);
    idle(); step();

    // Reset mid-stream with two samples in flight.
    vld_i[0] = 1'b1; sel_i[0] = 8'd5; step();
    sel_i[0] = 8'd6; step();
    idle();
    do_reset("midreset");
    for (int j = 0; j < 3; j++) begin
      step();
      chk($sformatf("midreset_novld_%0d", j), ov[0], 1'b0);
    end

    // Randomized traffic against the model, with one reset in the middle.
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < ND; d++) begin
        if ($urandom_range(0, 9) == 0) mode_i[d] = ~mode_i[d];
        vld_i[d] = ($urandom_range(0, 3) != 0);
        sel_i[d] = 8'($urandom & SMASK[d]);
        if ($urandom_range(0, 3) == 0)
          for (int c = 0; c < NN[d]; c++) chd[d][c] = 8'($urandom & WMASK[d]);
      end
      if (n == 200) do_reset("rnd_reset");
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_tree_pipe.md
# mux_tree_pipe

Parametrised, pipelined N-to-1 multiplexer for W-bit channels. It is built as a tree of registered 4:1 stages. It carries a valid bit and a channel tag alongside the selected data. An auto-scan mode steps through all channels in turn, for time-division readout. It is the general successor to the fixed 16:1 single-bit combinational mux. It sits between N parallel sources and a single serial consumer.

## Interface
- `W`, default 8: data width per channel (≥1).
- `N`, default 16: channel count (2..256). The tree is padded internally to 4^L inputs, with L = ceil(log4 N); padded inputs are tied to 0.
- `SW`, default `$clog2(N)`: select/tag width. Derived; not to be overridden.
- `clk`, input, 1: the single clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_data`, input, N*W: channel c occupies bits [c*W+W-1 : c*W].
- `in_valid`, input, 1: the current `in_data`/`sel` sample is valid.
- `sel`, input, SW: channel select. Used only when `mode`=0.
- `mode`, input, 1: 0 = direct select; 1 = auto-scan.
- `out_data`, output, W: selected channel data, L cycles after the sample.
- `out_valid`, output, 1: `out_data`/`out_ch` are valid.
- `out_ch`, output, SW: index of the channel delivered on `out_data`.

## Operation
- **Tree structure**
  - Stage k (k = 0..L-1) uses bits [2k+1:2k] of the effective select to pick 1 of 4 from the previous stage.
  - Each stage's output is registered.
  - The effective select (and its tag) is registered alongside, so the select bits for stage k are taken from the pipelined copy, never from live `sel`.
- **Effective channel**
  - `mode`=0: effective channel = `sel`.
  - `mode`=1: effective channel = `scan_ch`, the internal counter.
- **Out-of-range select**: if the effective channel is ≥ N, `out_data` = 0 and `out_valid` follows `in_valid` as normal. `out_ch` carries the requested index unchanged.
- **Scan counter (`scan_ch`, SW bits)**
  - Advances by 1 on each clock where `mode`=1 and `in_valid`=1.
  - Wraps from N-1 to 0; it never reaches N.
  - Holds when `in_valid`=0.
  - Forced to 0 on any clock where `mode`=0, so every entry into scan mode starts at channel 0.
- **Handshake**: none. There is no backpressure, and the pipeline advances every cycle. A cycle with `in_valid`=0 produces an `out_valid`=0 bubble L cycles later. Data and tag registers still load in bubble cycles; their values are don't-care while `out_valid`=0.
- **Mode change mid-stream**
  - Samples already in flight complete with the channel chosen at their launch.
  - The new mode applies from the sample on the same edge at which `mode` is first seen at its new value.
- **Reset** (asserted, including mid-operation):
  - Immediately clears every pipeline register, `scan_ch`, and all outputs.
  - In-flight samples are discarded; no output is produced for them after release.

## Timing
- Latency is exactly L cycles from sample edge to output. For N=16: L=2. For N=4: L=1. For N=5..16: L=2.
- Throughput is one sample per clock.
- Reset values:
  - `out_data` = 0, `out_valid` = 0, `out_ch` = 0.
  - `scan_ch` = 0.
  - All internal stage registers = 0.
- After `rst_n` deasserts, the first edge samples normally. The first possible `out_valid`=1 appears L edges later.
- Only the registered outputs drive the ports; there is no combinational path from inputs to outputs.

## Test plan
- **Direct select, N=16, W=8**: `in_data` channel c = 0x10+c, `in_valid`=1, `sel` stepping 0..15 one per clock. Required: from cycle 2, `out_data` = 0x10..0x1F in order, `out_ch` = 0..15, `out_valid`=1 throughout.
- **Auto-scan wrap, N=5, W=4**: `mode`=1, `in_valid`=1 for 12 clocks. Required: `out_ch` sequence 0,1,2,3,4,0,1,2,3,4,0,1, each with the matching data, 2 cycles after launch.
- **Scan hold and re-entry**:
  - `mode`=1, `in_valid` pattern 1,1,0,0,1. Required: `out_ch` 0,1,-,-,2, with `out_valid` 1,1,0,0,1.
  - Then `mode`=0 for 1 clock, then `mode`=1. Required: the next scan sample is channel 0.
- **Out-of-range select, N=10**: `sel`=12, `in_valid`=1. Required: L=2 cycles later, `out_data`=0, `out_ch`=12, `out_valid`=1.
- **Reset mid-stream, N=16**: launch samples on 2 consecutive edges, then drive `rst_n` low between edges for one cycle. Required: outputs are 0 immediately at assertion, with no `out_valid` pulse for the discarded samples after release.
- **Bubble propagation**: alternate `in_valid` 1/0 with direct select. Required: `out_valid` shows the same alternation delayed by exactly L cycles, and the data in valid cycles matches the selected channels.
